// File: rtl/chimera_cluster_pwr_seq.sv
// Per-cluster power sequencer: drain outstanding AXI traffic, isolate, gate clock,
// and reverse the sequence on wake-up. Each cluster is sequenced independently.
module chimera_cluster_pwr_seq #(
  parameter int unsigned NumClusters    = 5,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned SettleCycles   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumClusters-1:0] pwr_down_req_i,
  input  logic [NumClusters-1:0] txn_start_i,
  input  logic [NumClusters-1:0] txn_done_i,
  output logic [NumClusters-1:0] block_o,
  output logic [NumClusters-1:0] isolate_o,
  output logic [NumClusters-1:0] clk_en_o,
  output logic [NumClusters-1:0] off_o,
  output logic [NumClusters-1:0] err_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned TmrW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
  localparam logic [TmrW-1:0] TmrLoad = TmrW'(SettleCycles - 1);

  typedef enum logic [2:0] {
    ST_ACTIVE,
    ST_DRAIN,
    ST_ISO,
    ST_GATED,
    ST_WAKE
  } state_e;

  // {block, isolate, clk_en, off} for a given state
  function automatic logic [3:0] state_outs(input state_e s);
    case (s)
      ST_ACTIVE: state_outs = 4'b0010;
      ST_DRAIN:  state_outs = 4'b1010;
      ST_ISO:    state_outs = 4'b1110;
      ST_GATED:  state_outs = 4'b1101;
      ST_WAKE:   state_outs = 4'b1110;
      default:   state_outs = 4'b0010;
    endcase
  endfunction

  for (genvar g = 0; g < NumClusters; g++) begin : g_cluster
    state_e          state, state_nxt;
    logic [CntW-1:0] cnt, cnt_nxt;
    logic [TmrW-1:0] tmr, tmr_nxt;
    logic            ovf, unf, blk_start;
    logic            ovf_set, unf_set;
    logic            blk, iso, cen, off;
    logic            req, start, done;

    assign req   = pwr_down_req_i[g];
    assign start = txn_start_i[g];
    assign done  = txn_done_i[g];

    // Saturating outstanding counter; hitting either bound flags an error
    always_comb begin
      cnt_nxt = cnt;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (start && !done) begin
        if (cnt == CntMax) ovf_set = 1'b1;
        else               cnt_nxt = cnt + CntW'(1);
      end else if (done && !start) begin
        if (cnt == '0) unf_set = 1'b1;
        else           cnt_nxt = cnt - CntW'(1);
      end
    end

    always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      case (state)
        ST_ACTIVE: if (req) state_nxt = ST_DRAIN;
        ST_DRAIN: begin
          if (!req) begin
            state_nxt = ST_ACTIVE;
          end else if (cnt_nxt == '0 && !start) begin
            state_nxt = ST_ISO;
            tmr_nxt   = TmrLoad;
          end
        end
        ST_ISO: begin
          if (tmr == '0) state_nxt = ST_GATED;
          else           tmr_nxt   = tmr - TmrW'(1);
        end
        ST_GATED: begin
          if (!req) begin
            state_nxt = ST_WAKE;
            tmr_nxt   = TmrLoad;
          end
        end
        ST_WAKE: begin
          // A request that reappears during wake-up sends the cluster back to ISO
          if (tmr == '0) begin
            if (req) begin
              state_nxt = ST_ISO;
              tmr_nxt   = TmrLoad;
            end else begin
              state_nxt = ST_ACTIVE;
            end
          end else begin
            tmr_nxt = tmr - TmrW'(1);
          end
        end
        default: state_nxt = ST_ACTIVE;
      endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state               <= ST_ACTIVE;
        cnt                 <= '0;
        tmr                 <= '0;
        ovf                 <= 1'b0;
        unf                 <= 1'b0;
        blk_start           <= 1'b0;
        {blk, iso, cen, off} <= 4'b0010;
      end else begin
        state               <= state_nxt;
        cnt                 <= cnt_nxt;
        tmr                 <= tmr_nxt;
        ovf                 <= ovf | ovf_set;
        unf                 <= unf | unf_set;
        blk_start           <= blk_start | (start & blk);
        {blk, iso, cen, off} <= state_outs(state_nxt);
      end
    end

    assign block_o[g]   = blk;
    assign isolate_o[g] = iso;
    assign clk_en_o[g]  = cen;
    assign off_o[g]     = off;
    assign err_o[g]     = ovf | unf | blk_start;
  end

endmodule
